vrf_banked: RTL
===============

Name: vrf_banked

Overview:
Lane-banked vector register file; successor to the flat multi-lane vrf. Element e of vector v lives in bank (e mod lanes_p), at row e/lanes_p, so each lane owns one bank and lanes can never conflict. Each bank has 2 registered read ports with write-first bypass and 1 write port. A clear sequencer zeroes the whole array after reset or on request, and `ready_o` gates all traffic. Sits between the vector issue/sequencer stage and the lane ALUs.

Parameters:
- els_p, 32, number of vector registers.
- vlen_p, 8, elements per vector; must be a multiple of lanes_p.
- vdw_p, 32, bits per element.
- lanes_p, 4, number of lanes (= number of banks).
- rows_lp (local), vlen_p/lanes_p, rows per vector in one bank.
- addr_width_lp (local), BSG_SAFE_CLOG2(els_p) + BSG_SAFE_CLOG2(rows_lp), address width as {vreg, row}.
- depth_lp (local), els_p*rows_lp, entries per bank.

Ports:
- clk_i  in  1  single clock; all state on posedge.
- reset_i  in  1  synchronous, active-high reset.
- ready_o  out  1  array usable; low while clearing.
- clear_i  in  1  start a full zero-clear; honoured only when ready_o=1.
- r0_v_i  in  lanes_p  per-lane read-port-0 request.
- r0_addr_i  in  lanes_p x addr_width_lp  {vreg, row} for port 0.
- r0_v_o  out  lanes_p  port-0 data valid.
- r0_data_o  out  lanes_p x vdw_p  port-0 read data.
- r1_v_i, r1_addr_i, r1_v_o, r1_data_o  same as port 0, for port 1.
- w_en_i  in  lanes_p  per-lane write enable.
- w_addr_i  in  lanes_p x addr_width_lp  {vreg, row} write address.
- w_data_i  in  lanes_p x vdw_p  write data.

Behaviour:
- FSM states: CLEAR, READY.
- Reset: state=CLEAR, clear counter=0, ready_o=0, all r*_v_o=0, all r*_data_o=0. Reset asserted mid-clear or mid-traffic restarts the clear at counter 0.
- CLEAR: every cycle, write 0 to entry [counter] in all banks in parallel. Counter increments by 1. When counter=depth_lp-1, that write completes and the next state is READY. The clear takes exactly depth_lp cycles. ready_o goes high on the cycle after the last clear write.
- READY to CLEAR on clear_i=1. ready_o drops the next cycle. clear_i is ignored while in CLEAR.
- While ready_o=0: r*_v_i and w_en_i are ignored, r*_v_o=0, r*_data_o holds its last value, and no user write reaches the array.
- Read:
  - Registered, latency 1. A request r*_v_i[i]=1 at cycle t gives r*_v_o[i]=1 with data at t+1. r*_v_o[i]=0 when there was no request.
  - r*_data_o holds its value when there is no request.
- Write: when w_en_i[i]=1 at posedge t, bank i entry w_addr_i[i] is updated. It is visible to requests at t+1 onward.
- Bypass (write-first): a same-cycle read of the same lane and same address as an enabled write returns w_data_i.
- Both ports may read the same address in the same cycle; both return identical data.
- Lanes are independent; no cross-lane arbitration is needed.
- An address with row >= rows_lp or vreg >= els_p is illegal: simulation $fatal when the request is valid, unspecified in synthesis.

Decomposition:
- Package vrf_pkg: FSM state enum (CLEAR, READY) and the address struct {vreg, row}.
- Sub-module vrf_bank: 1W/2R array of depth_lp x vdw_p with registered outputs and write-first bypass. Instantiated lanes_p times.
- Top level holds the clear FSM/counter and muxes clear writes onto each bank's write port.

Test Plan:
All scenarios use els_p=4, vlen_p=8, lanes_p=4, vdw_p=32 (rows_lp=2, depth_lp=8).
1. Reset clear: release reset at cycle 0 -> ready_o=0 for cycles 0-7, =1 at cycle 8. Reading every {vreg, row} on both ports then returns 0.
2. Write then read: lane 2 writes {3,1}=0xDEADBEEF at t, read {3,1} on r0 at t+1 -> r0_v_o[2]=1, r0_data_o[2]=0xDEADBEEF at t+2. Lane 0 {3,1} still reads 0.
3. Bypass: lane 1 writes {2,0}=0x12345678 and r1 reads {2,0} in the same cycle -> r1_data_o[1]=0x12345678 next cycle. Both ports reading the same address return the same value.
4. Clear request: fill all entries with 0xA5A5A5A5, pulse clear_i -> ready_o low for 8 cycles. Reads and writes issued during that window give r*_v_o=0 and are dropped. Afterwards every entry reads 0.
5. Reset mid-clear: assert reset at clear cycle 5 -> counter restarts, and ready_o rises exactly 8 cycles after reset deasserts.
6. All-lane stress: random writes and both-port reads on all 4 lanes for 2000 cycles, checked against a scoreboard model including bypass -> zero mismatches, and r*_v_o tracks r*_v_i delayed by 1.

Source files
------------

// File: rtl/vrf_pkg.sv
// Shared types and helpers for the lane-banked vector register file.
// The {vreg, row} address struct depends on module parameters, so it is declared in vrf_banked.
package vrf_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } vrf_state_e;

    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic logic addr_legal(input int vreg, input int row, input int els, input int rows);
        return (vreg < els) && (row < rows);
    endfunction

endpackage

// File: rtl/vrf_bank.sv
// One lane's bank: 1 write port, 2 registered read ports with write-first bypass.
module vrf_bank
    import vrf_pkg::*;
#(
    parameter  int depth_p = 8,
    parameter  int width_p = 32,
    localparam int aw_lp   = safe_clog2(depth_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    w_en_i,
    input  logic [aw_lp-1:0]        w_addr_i,
    input  logic [width_p-1:0]      w_data_i,
    input  logic [1:0]              r_v_i,
    input  logic [1:0][aw_lp-1:0]   r_addr_i,
    output logic [1:0]              r_v_o,
    output logic [1:0][width_p-1:0] r_data_o
);

    logic [width_p-1:0]      mem_q [depth_p];
    logic [1:0]              r_v_q;
    logic [1:0][width_p-1:0] r_data_q, r_data_d;

    // NOTE: the storage array has no reset; the clear sequencer zeroes it so it maps onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (w_en_i) begin
            mem_q[w_addr_i] <= w_data_i;
        end
    end

    always_comb begin
        // NOTE: default the next-state value first so no path through this block infers a latch.
        r_data_d = r_data_q;
        for (int p = 0; p < 2; p++) begin
            if (r_v_i[p]) begin
                r_data_d[p] = (w_en_i && (w_addr_i == r_addr_i[p])) ? w_data_i : mem_q[r_addr_i[p]];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_v_q    <= '0;
            r_data_q <= '0;
        end else begin
            r_v_q    <= r_v_i;
            r_data_q <= r_data_d;
        end
    end

    assign r_v_o    = r_v_q;
    assign r_data_o = r_data_q;

endmodule

// File: rtl/vrf_banked.sv
// Lane-banked vector register file: element e of a vector lives in bank e mod lanes_p.
// A clear sequencer zeroes every bank after reset or on request; ready_o gates all traffic.
module vrf_banked
    import vrf_pkg::*;
#(
    parameter  int els_p         = 32,
    parameter  int vlen_p        = 8,
    parameter  int vdw_p         = 32,
    parameter  int lanes_p       = 4,
    localparam int rows_lp       = vlen_p / lanes_p,
    localparam int vreg_w_lp     = safe_clog2(els_p),
    localparam int row_w_lp      = safe_clog2(rows_lp),
    localparam int addr_width_lp = vreg_w_lp + row_w_lp,
    localparam int depth_lp      = els_p * rows_lp
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    output logic                                   ready_o,
    input  logic                                   clear_i,
    input  logic [lanes_p-1:0]                     r0_v_i,
    input  logic [lanes_p-1:0][addr_width_lp-1:0]  r0_addr_i,
    output logic [lanes_p-1:0]                     r0_v_o,
    output logic [lanes_p-1:0][vdw_p-1:0]          r0_data_o,
    input  logic [lanes_p-1:0]                     r1_v_i,
    input  logic [lanes_p-1:0][addr_width_lp-1:0]  r1_addr_i,
    output logic [lanes_p-1:0]                     r1_v_o,
    output logic [lanes_p-1:0][vdw_p-1:0]          r1_data_o,
    input  logic [lanes_p-1:0]                     w_en_i,
    input  logic [lanes_p-1:0][addr_width_lp-1:0]  w_addr_i,
    input  logic [lanes_p-1:0][vdw_p-1:0]          w_data_i
);

    localparam int idx_w_lp = safe_clog2(depth_lp);

    typedef struct packed {
        logic [vreg_w_lp-1:0] vreg;
        logic [row_w_lp-1:0]  row;
    } vrf_addr_s;

    function automatic logic [idx_w_lp-1:0] to_index(input logic [addr_width_lp-1:0] a);
        vrf_addr_s s;
        s = a;
        return idx_w_lp'(int'(s.vreg) * rows_lp + int'(s.row));
    endfunction

    function automatic logic is_legal(input logic [addr_width_lp-1:0] a);
        vrf_addr_s s;
        s = a;
        return addr_legal(int'(s.vreg), int'(s.row), els_p, rows_lp);
    endfunction

    vrf_state_e          state_q;
    logic [idx_w_lp-1:0] clr_cnt_q;
    logic                ready_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + idx_w_lp'(1);
                    if (clr_cnt_q == idx_w_lp'(depth_lp - 1)) begin
                        state_q   <= READY;
                        ready_q   <= 1'b1;
                        clr_cnt_q <= '0;
                    end
                end
                READY: begin
                    if (clear_i) begin
                        state_q <= CLEAR;
                        ready_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign ready_o = ready_q;

    // While clearing, every bank's write port is taken by the zero-fill and user reads are masked.
    for (genvar l = 0; l < lanes_p; l++) begin : g_lane
        logic                     bank_w_en;
        logic [idx_w_lp-1:0]      bank_w_idx;
        logic [vdw_p-1:0]         bank_w_data;
        logic [1:0]               bank_r_v;
        logic [1:0][idx_w_lp-1:0] bank_r_idx;
        logic [1:0]               bank_r_v_o;
        logic [1:0][vdw_p-1:0]    bank_r_data;

        assign bank_w_en     = ready_q ? w_en_i[l] : 1'b1;
        assign bank_w_idx    = ready_q ? to_index(w_addr_i[l]) : clr_cnt_q;
        assign bank_w_data   = ready_q ? w_data_i[l] : '0;
        assign bank_r_v      = {r1_v_i[l] & ready_q, r0_v_i[l] & ready_q};
        assign bank_r_idx[0] = to_index(r0_addr_i[l]);
        assign bank_r_idx[1] = to_index(r1_addr_i[l]);

        vrf_bank #(
            .depth_p (depth_lp),
            .width_p (vdw_p)
        ) u_bank (
            .clk_i    (clk_i),
            .reset_i  (reset_i),
            .w_en_i   (bank_w_en),
            .w_addr_i (bank_w_idx),
            .w_data_i (bank_w_data),
            .r_v_i    (bank_r_v),
            .r_addr_i (bank_r_idx),
            .r_v_o    (bank_r_v_o),
            .r_data_o (bank_r_data)
        );

        assign r0_v_o[l]    = bank_r_v_o[0];
        assign r1_v_o[l]    = bank_r_v_o[1];
        assign r0_data_o[l] = bank_r_data[0];
        assign r1_data_o[l] = bank_r_data[1];
    end

    always @(posedge clk_i) begin
        if (!reset_i && ready_q) begin
            for (int l = 0; l < lanes_p; l++) begin
                assert (!(r0_v_i[l] && !is_legal(r0_addr_i[l])))
                    else $fatal(1, "vrf_banked: illegal r0 address on lane %0d", l);
                assert (!(r1_v_i[l] && !is_legal(r1_addr_i[l])))
                    else $fatal(1, "vrf_banked: illegal r1 address on lane %0d", l);
                assert (!(w_en_i[l] && !is_legal(w_addr_i[l])))
                    else $fatal(1, "vrf_banked: illegal write address on lane %0d", l);
            end
        end
    end

endmodule
